ram_dma_ci_ctrl: RTL and testbench



---
 rtl/ram_dma_ci_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_ram_dma_ci_ctrl.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_dma_ci_ctrl.sv
// ram_dma_ci_ctrl -- custom-instruction scratchpad with an in-memory block engine.
//
// A dual-port synchronous RAM of nrOfEntries 32-bit words. Port A serves
// single-word CPU READ/WRITE custom instructions; port B belongs to a block
// engine that copies (and optionally fills) memory ranges in the background,
// so the CPU is never stalled by a block operation.
//
// Build option:
//   RAM_DMA_CI_FILL_EN  defined -> op 100 FILL and the FILLW engine state exist.
//                       undefined -> op 100 is an unknown op.
//
// Ports:
//   clock   in   1   single clock, rising edge
//   reset   in   1   synchronous, active-high
//   start   in   1   CI start, held with iseId/operands until done
//   iseId   in   8   CI identifier; only customInstructionId is answered
//   valueA  in  32   [31:29] op, [27:16] len, [AW-1:0] address
//   valueB  in  32   write data / copy destination / fill pattern
//   result  out 32   CI result, 0 whenever done is 0
//   done    out  1   one-cycle completion pulse per instruction
//   busy    out  1   block engine active
module ram_dma_ci_ctrl #(
  parameter logic [7:0] customInstructionId = 8'h00,
  parameter int         nrOfEntries         = 512
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  iseId,
  input  logic [31:0] valueA,
  input  logic [31:0] valueB,
  output logic [31:0] result,
  output logic        done,
  output logic        busy
);

  localparam int AW = $clog2(nrOfEntries);

  localparam logic [2:0] OP_READ   = 3'b000;
  localparam logic [2:0] OP_WRITE  = 3'b001;
  localparam logic [2:0] OP_COPY   = 3'b010;
  localparam logic [2:0] OP_STATUS = 3'b011;
`ifdef RAM_DMA_CI_FILL_EN
  localparam logic [2:0] OP_FILL   = 3'b100;
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_WRITE
`ifdef RAM_DMA_CI_FILL_EN
    , S_FILLW
`endif
  } state_e;

  logic [31:0]   mem [nrOfEntries];
  logic [31:0]   rd_a;         // port A registered read data
  logic [31:0]   rd_b;         // port B word in flight between READ and WRITE
  state_e        state, state_nxt;
  logic [AW-1:0] src_ptr, dst_ptr;
  logic [11:0]   remaining;    // engine words not yet written
  logic          rd_pend;      // a READ address was presented last cycle

  logic [2:0]    op;
  logic [11:0]   len;
  logic [AW-1:0] addr;
  logic          own;
  logic          cpu_we;
  logic          accept_copy;
  logic          eng_we;
  logic          eng_clash;
  logic [31:0]   eng_wdata;
  logic          last_word;
`ifdef RAM_DMA_CI_FILL_EN
  logic [31:0]   fill_data;
  logic          accept_fill;
`endif

  // Upper address bits and reserved operand fields are intentionally ignored.
  logic unused_operand_bits;
  assign unused_operand_bits = ^{valueA, valueB};

  assign op        = valueA[31:29];
  assign len       = valueA[27:16];
  assign addr      = valueA[AW-1:0];
  assign own       = start && (iseId == customInstructionId) && !reset;
  assign busy      = (state != S_IDLE);
  assign last_word = (remaining == 12'd1);
  // The CPU port wins a same-address collision; the engine simply loses that word.
  assign eng_clash = cpu_we && (addr == dst_ptr);

  // Instruction decode and result mux.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    done        = 1'b0;
    result      = 32'h0;
    cpu_we      = 1'b0;
    accept_copy = 1'b0;
`ifdef RAM_DMA_CI_FILL_EN
    accept_fill = 1'b0;
`endif
    if (own) begin
      case (op)
        OP_READ: begin
          if (rd_pend) begin
            done   = 1'b1;
            result = rd_a;
          end
        end
        OP_WRITE: begin
          done   = 1'b1;
          cpu_we = 1'b1;
        end
        OP_COPY: begin
          done = 1'b1;
          if (busy) result = 32'hFFFF_FFFF;
          else      accept_copy = (len != 12'd0);
        end
        OP_STATUS: begin
          done   = 1'b1;
          result = {busy, 19'b0, remaining};
        end
`ifdef RAM_DMA_CI_FILL_EN
        OP_FILL: begin
          done = 1'b1;
          if (busy) result = 32'hFFFF_FFFF;
          else      accept_fill = (len != 12'd0);
        end
`endif
        default: begin
          done   = 1'b1;
          result = 32'hFFFF_FFFF;
        end
      endcase
    end
  end

  // Engine next state and port B write selection.
  always_comb begin
    state_nxt = state;
    eng_we    = 1'b0;
    eng_wdata = rd_b;
    case (state)
      S_IDLE: begin
        if (accept_copy) state_nxt = S_READ;
`ifdef RAM_DMA_CI_FILL_EN
        if (accept_fill) state_nxt = S_FILLW;
`endif
      end
      S_READ:  state_nxt = S_WRITE;
      S_WRITE: begin
        eng_we    = !reset;
        state_nxt = last_word ? S_IDLE : S_READ;
      end
`ifdef RAM_DMA_CI_FILL_EN
      S_FILLW: begin
        eng_we    = !reset;
        eng_wdata = fill_data;
        state_nxt = last_word ? S_IDLE : S_FILLW;
      end
`endif
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_pend   <= 1'b0;
      remaining <= 12'd0;
      src_ptr   <= '0;
      dst_ptr   <= '0;
    end else begin
      // A READ completes one cycle after its address is presented; clearing on
      // the completion cycle lets back-to-back READs re-arm.
      rd_pend <= own && (op == OP_READ) && !rd_pend;
      if (accept_copy) begin
        src_ptr   <= addr;
        dst_ptr   <= valueB[AW-1:0];
        remaining <= len;
      end
`ifdef RAM_DMA_CI_FILL_EN
      if (accept_fill) begin
        dst_ptr   <= addr;
        remaining <= len;
        fill_data <= valueB;
      end
`endif
      if (state == S_READ) src_ptr <= src_ptr + AW'(1);
      // Pointers and count advance even when a clash suppressed the store.
      if (eng_we) begin
        dst_ptr   <= dst_ptr + AW'(1);
        remaining <= remaining - 12'd1;
      end
    end
  end

  // NOTE: the RAM array has no reset so it maps onto block RAM; contents survive reset.
  always_ff @(posedge clock) begin
    if (cpu_we)                mem[addr]    <= valueB;
    if (eng_we && !eng_clash)  mem[dst_ptr] <= eng_wdata;
    rd_a <= mem[addr];
    if (state == S_READ) rd_b <= mem[src_ptr];
  end

endmodule

// File: tb/tb_ram_dma_ci_ctrl.sv
// Self-checking bench for ram_dma_ci_ctrl: random RAM image and random copies
// compared against a word-array model using sequential-copy semantics and
// cycle formulas for busy/remaining.
module tb_ram_dma_ci_ctrl;

  localparam int         D  = 512;
  localparam logic [7:0] ID = 8'h00;

  localparam logic [2:0] OP_READ   = 3'b000;
  localparam logic [2:0] OP_WRITE  = 3'b001;
  localparam logic [2:0] OP_COPY   = 3'b010;
  localparam logic [2:0] OP_STATUS = 3'b011;
  localparam logic [2:0] OP_FILL   = 3'b100;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  iseId;
  logic [31:0] valueA, valueB;
  logic [31:0] result;
  logic        done, busy;

  logic [31:0] m [D];
  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  ram_dma_ci_ctrl #(.customInstructionId(ID), .nrOfEntries(D)) dut (
    .clock(clock), .reset(reset), .start(start), .iseId(iseId),
    .valueA(valueA), .valueB(valueB), .result(result), .done(done), .busy(busy)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int wrap(input int a);
    return ((a % D) + D) % D;
  endfunction

  // Sequential ascending word copy; count < n models an interrupted copy.
  task automatic model_copy(input int src, input int dst, input int count);
    for (int i = 0; i < count; i++) m[wrap(dst + i)] = m[wrap(src + i)];
  endtask

  // STATUS expected d cycles after a copy of n words was accepted.
  function automatic logic [31:0] exp_status(input int d, input int n);
    int   written;
    logic b;
    b       = (d >= 1) && (d <= 2 * n);
    written = (d < 3) ? 0 : (d - 3) / 2 + 1;
    if (written > n) written = n;
    return {b, 19'b0, 12'(n - written)};
  endfunction

  // Advance so the next issue lands in cycle target.
  task automatic wait_cycle(input int target);
    while (cyc < target) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Drive one instruction in the current cycle t; sample at t (and t+1 for READ).
  task automatic issue(input logic [2:0] op, input logic [11:0] len, input logic [11:0] addr,
                       input logic [31:0] vb, input logic [7:0] id,
                       output logic d0, output logic [31:0] r0,
                       output logic d1, output logic [31:0] r1, output int t);
    @(negedge clock);
    start  = 1'b1;
    iseId  = id;
    valueA = {op, 1'b0, len, 4'b0, addr};
    valueB = vb;
    #1;
    d0 = done;
    r0 = result;
    t  = cyc;
    d1 = 1'b0;
    r1 = 32'h0;
    if (op == OP_READ) begin
      @(negedge clock);
      #1;
      d1 = done;
      r1 = result;
    end
    @(posedge clock);
    #1;
    start  = 1'b0;
    valueA = 32'h0;
    valueB = 32'h0;
  endtask

  task automatic do_read(input int addr, input string tag);
    logic d0, d1;
    logic [31:0] r0, r1;
    int t;
    issue(OP_READ, 12'd0, 12'(addr), 32'h0, ID, d0, r0, d1, r1, t);
    check($sformatf("%s[%0d]", tag, addr), {d0, d1, r1}, {1'b0, 1'b1, m[addr]});
  endtask

  task automatic do_write(input int addr, input logic [31:0] data, input string tag);
    logic d0, d1;
    logic [31:0] r0, r1;
    int t;
    issue(OP_WRITE, 12'd0, 12'(addr), data, ID, d0, r0, d1, r1, t);
    m[addr] = data;
    check(tag, {d0, r0}, {1'b1, 32'h0});
  endtask

  task automatic do_status(input logic [31:0] exp, input string tag);
    logic d0, d1;
    logic [31:0] r0, r1;
    int t;
    issue(OP_STATUS, 12'd0, 12'd0, 32'h0, ID, d0, r0, d1, r1, t);
    check(tag, {d0, r0}, {1'b1, exp});
  endtask

  // Count busy cycles up to last+2; busy must rise at t+1 and last through 'last'.
  task automatic watch_busy(input int t, input int last, input string tag);
    int cnt = 0;
    int first = -1;
    while (cyc <= last + 2) begin
      @(negedge clock);
      if (busy === 1'b1) begin
        cnt++;
        if (first < 0) first = cyc;
      end
      @(posedge clock);
      #1;
    end
    check({tag, "_busy_len"}, 64'(cnt), 64'(last - t));
    check({tag, "_busy_first"}, 64'(first), 64'(t + 1));
  endtask

  initial begin
    logic d0, d1;
    logic [31:0] r0, r1;
    int t, src, dst, n, dly;

    reset = 1'b1; start = 1'b0; iseId = 8'h0; valueA = 32'h0; valueB = 32'h0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("reset_outputs", {done, busy, result}, 34'h0);
    @(posedge clock);
    #1;
    reset = 1'b0;

    // Random RAM image, mirrored in the model.
    for (int i = 0; i < D; i++) begin
      m[i] = $urandom;
      issue(OP_WRITE, 12'd0, i[11:0], m[i], ID, d0, r0, d1, r1, t);
    end
    do_status(32'h0, "status_after_reset");

    // Single-word write and read.
    do_write(5, 32'hCAFE_F00D, "write5");
    do_read(5, "read5");

    // Foreign instruction id: no response, no effect.
    issue(OP_WRITE, 12'd0, 12'd6, 32'h1234_5678, 8'h01, d0, r0, d1, r1, t);
    check("foreign_write", {d0, r0}, 33'h0);
    issue(OP_READ, 12'd0, 12'd6, 32'h0, 8'h3C, d0, r0, d1, r1, t);
    check("foreign_read", {d0, r0, d1, r1}, 66'h0);
    do_read(6, "foreign_no_effect");

    // Basic copy 0..3 -> 100..103.
    for (int i = 0; i < 4; i++) do_write(i, 32'(i + 1), "preload");
    issue(OP_COPY, 12'd4, 12'd0, 32'd100, ID, d0, r0, d1, r1, t);
    check("copy4_accept", {d0, r0}, {1'b1, 32'h0});
    model_copy(0, 100, 4);
    watch_busy(t, t + 8, "copy4");
    do_status(32'h0, "copy4_status_after");
    for (int i = 100; i < 104; i++) do_read(i, "copy4_dst");

    // Long copy with STATUS and a rejected second copy while running.
    issue(OP_COPY, 12'd16, 12'd40, 32'd140, ID, d0, r0, d1, r1, t);
    check("copy16_accept", {d0, r0}, {1'b1, 32'h0});
    dly = 3 + $urandom_range(0, 24);
    wait_cycle(t + dly);
    do_status(exp_status(dly, 16), "copy16_status_mid");
    issue(OP_COPY, 12'd8, 12'd0, 32'd400, ID, d0, r0, d1, r1, n);
    check("copy16_reject", {d0, r0}, {1'b1, 32'hFFFF_FFFF});
    wait_cycle(t + 33);
    do_status(exp_status(33, 16), "copy16_status_end");
    model_copy(40, 140, 16);
    for (int i = 140; i < 156; i++) do_read(i, "copy16_dst");
    do_read(400, "rejected_copy_no_effect");

    // Wrapping, self-overlapping copy 510 -> 1.
    issue(OP_COPY, 12'd4, 12'd510, 32'd1, ID, d0, r0, d1, r1, t);
    check("wrap_accept", {d0, r0}, {1'b1, 32'h0});
    model_copy(510, 1, 4);
    watch_busy(t, t + 8, "wrap");
    for (int i = 0; i < 6; i++) do_read(i, "wrap_mem");
    do_read(510, "wrap_mem");
    do_read(511, "wrap_mem");

    // CPU write colliding with the engine's second write.
    issue(OP_COPY, 12'd4, 12'd60, 32'd160, ID, d0, r0, d1, r1, t);
    wait_cycle(t + 4);
    do_write(161, 32'hDEAD_BEEF, "clash_write");
    do_status(exp_status(5, 4), "clash_status_mid");
    wait_cycle(t + 9);
    do_status(32'h0, "clash_status_end");
    model_copy(60, 160, 4);
    m[161] = 32'hDEAD_BEEF;
    for (int i = 160; i < 164; i++) do_read(i, "clash_mem");

    // Fill, or unknown op when the fill feature is absent.
    issue(OP_FILL, 12'd3, 12'd20, 32'h5A5A_5A5A, ID, d0, r0, d1, r1, t);
`ifdef RAM_DMA_CI_FILL_EN
    check("fill_accept", {d0, r0}, {1'b1, 32'h0});
    for (int i = 20; i < 23; i++) m[i] = 32'h5A5A_5A5A;
    watch_busy(t, t + 3, "fill");
`else
    check("fill_disabled", {d0, r0}, {1'b1, 32'hFFFF_FFFF});
    @(negedge clock);
    check("fill_disabled_busy", busy, 1'b0);
    @(posedge clock);
    #1;
`endif
    for (int i = 19; i < 24; i++) do_read(i, "fill_mem");

    // Unknown opcodes.
    for (int k = 5; k < 8; k++) begin
      issue(k[2:0], 12'd2, 12'd30, 32'd31, ID, d0, r0, d1, r1, t);
      check($sformatf("unknown_op%0d", k), {d0, r0}, {1'b1, 32'hFFFF_FFFF});
    end
    do_read(31, "unknown_no_effect");

    // Zero-length copy.
    issue(OP_COPY, 12'd0, 12'd0, 32'd450, ID, d0, r0, d1, r1, t);
    check("len0_accept", {d0, r0}, {1'b1, 32'h0});
    @(negedge clock);
    check("len0_busy", busy, 1'b0);
    @(posedge clock);
    #1;
    do_read(450, "len0_no_effect");

    // Random copies, including overlap and wrap.
    for (int it = 0; it < 4; it++) begin
      src = $urandom_range(0, D - 1);
      dst = $urandom_range(0, D - 1);
      n   = $urandom_range(1, 24);
      issue(OP_COPY, 12'(n), 12'(src), 32'(dst), ID, d0, r0, d1, r1, t);
      check($sformatf("rand%0d_accept", it), {d0, r0}, {1'b1, 32'h0});
      model_copy(src, dst, n);
      watch_busy(t, t + 2 * n, $sformatf("rand%0d", it));
      for (int i = -1; i <= n; i++) do_read(wrap(dst + i), $sformatf("rand%0d_mem", it));
    end

    // Reset after three words of a ten-word copy.
    issue(OP_COPY, 12'd10, 12'd200, 32'd300, ID, d0, r0, d1, r1, t);
    wait_cycle(t + 7);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    check("reset_mid_busy", busy, 1'b0);
    @(posedge clock);
    #1;
    do_status(32'h0, "reset_mid_status");
    model_copy(200, 300, 3);
    for (int i = 300; i < 310; i++) do_read(i, "reset_mid_mem");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
